npu_act_wr_arbiter: RTL



---
 rtl/npu_act_wr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/npu_act_wr_arbiter.sv
// Round-robin arbiter for the activation memory NPU write port.
// One lane is granted per cycle. The memory write and the lane ack are registered together.
module npu_act_wr_arbiter #(
  parameter int unsigned NUM_REQ = 32,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      layer_start_p,
  input  logic [NUM_REQ-1:0]        hw_mem_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] hw_mem_wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] hw_mem_wr_data,
  output logic [NUM_REQ-1:0]        hw_mem_wr_ack_p,
  output logic                      act_mem_wr_en,
  output logic [ADDR_W-1:0]         act_mem_wr_addr,
  output logic [DATA_W-1:0]         act_mem_wr_data,
  output logic                      wr_drained,
  output logic [15:0]               wr_count,
  output logic [4:0]                grant_lane
);

  logic [4:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               en_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [4:0]         grant_q;
  logic [15:0]        count_q, count_d;
  logic               drained_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] rot;
  logic [4:0]         win_off;
  logic               win_found;
  logic [4:0]         win_idx;
  logic [5:0]         win_sum;
  logic [5:0]         nxt_ptr;

  always_comb begin
    eligible  = hw_mem_wr & ~ack_q;
    // Rotate so that bit 0 of rot corresponds to lane rr_ptr_q.
    rot       = NUM_REQ'({eligible, eligible} >> rr_ptr_q);
    win_found = |rot;
    win_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) win_off = 5'(i);
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    if (win_sum >= 6'(NUM_REQ)) win_sum = win_sum - 6'(NUM_REQ);
    win_idx = win_sum[4:0];
    nxt_ptr = {1'b0, win_idx} + 6'd1;
    if (nxt_ptr >= 6'(NUM_REQ)) nxt_ptr = '0;
  end

  always_comb begin
    ack_d  = '0;
    addr_d = addr_q;
    data_d = data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_found && (win_idx == 5'(i))) begin
        ack_d[i] = 1'b1;
        addr_d   = hw_mem_wr_addr[i*ADDR_W +: ADDR_W];
        data_d   = hw_mem_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    if (win_found) begin
      rr_ptr_d = nxt_ptr[4:0];
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
    // A grant issued in the layer-start cycle is the first write of the new layer.
    if (layer_start_p) begin
      rr_ptr_d = '0;
      count_d  = {15'd0, win_found};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      ack_q     <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      grant_q   <= '0;
      count_q   <= '0;
      drained_q <= 1'b1;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      ack_q     <= ack_d;
      en_q      <= win_found;
      addr_q    <= addr_d;
      data_q    <= data_d;
      if (win_found) grant_q <= win_idx;
      count_q   <= count_d;
      drained_q <= (hw_mem_wr == '0) && !en_q;
    end
  end

  assign hw_mem_wr_ack_p = ack_q;
  assign act_mem_wr_en   = en_q;
  assign act_mem_wr_addr = addr_q;
  assign act_mem_wr_data = data_q;
  assign grant_lane      = grant_q;
  assign wr_count        = count_q;
  assign wr_drained      = drained_q;

endmodule
